video_timing_gen: RTL

//  Raster timing generator. Produces the pixel position (x, y) plus hsync, vsync
//  and blank for one video mode, one pixel per enabled clock.

---
 rtl/video_timing_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (one pixel per enabled clock).
// Walks an (h, v) position over the full raster of one video mode. It emits the
// registered position x/y, hsync, vsync and blank. All outputs are mutually aligned.
// Optional feature macro: VTG_FRAME_STROBE_EN adds a one-en-cycle frame_start
// strobe on the output where x==0 and y==0.
module video_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        hs,
  output logic        vs,
  output logic        blk
`ifdef VTG_FRAME_STROBE_EN
  ,
  output logic        frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to elaborate a mode whose raster does not fit the 12b/11b counters.
  if (H_TOTAL > 4096) begin : g_bad_h_total
    $error("video_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_bad_v_total
    $error("video_timing_gen: V_TOTAL exceeds 2048");
  end

  // Boundaries are one bit wider than the counters so that an end bound equal
  // to the full raster size (4096 / 2048) does not truncate to zero.
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT_END  = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_BEG = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_END = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] h_r;
  logic [10:0] v_r;
  logic [11:0] h_next_s;
  logic [10:0] v_next_s;
  logic        h_wrap_s;
  logic        hs_next_s;
  logic        vs_next_s;
  logic        blk_next_s;
  logic        frame_next_s;
  logic [12:0] h_ext_s;
  logic [11:0] v_ext_s;

  // Next raster position and the output values decoded from the current position.
  always_comb begin
    h_ext_s      = {1'b0, h_r};
    v_ext_s      = {1'b0, v_r};
    h_wrap_s     = (h_r == H_LAST);
    h_next_s     = h_r + 12'd1;
    v_next_s     = v_r;
    hs_next_s    = ~HS_POL;
    vs_next_s    = ~VS_POL;
    blk_next_s   = 1'b1;
    frame_next_s = 1'b0;

    if (h_wrap_s) begin
      h_next_s = 12'd0;
      if (v_r == V_LAST) begin
        v_next_s = 11'd0;
      end else begin
        v_next_s = v_r + 11'd1;
      end
    end else begin
      v_next_s = v_r;
    end

    if ((h_ext_s >= H_SYNC_BEG) && (h_ext_s < H_SYNC_END)) begin
      hs_next_s = HS_POL;
    end else begin
      hs_next_s = ~HS_POL;
    end

    // vs depends on v only, so it can only change together with x==0.
    if ((v_ext_s >= V_SYNC_BEG) && (v_ext_s < V_SYNC_END)) begin
      vs_next_s = VS_POL;
    end else begin
      vs_next_s = ~VS_POL;
    end

    if ((h_ext_s < H_ACT_END) && (v_ext_s < V_ACT_END)) begin
      blk_next_s = 1'b0;
    end else begin
      blk_next_s = 1'b1;
    end

    if ((h_r == 12'd0) && (v_r == 11'd0)) begin
      frame_next_s = 1'b1;
    end else begin
      frame_next_s = 1'b0;
    end
  end

  // Counters and aligned outputs advance together on enabled pixels; reset wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_r <= 12'd0;
      v_r <= 11'd0;
      x   <= 12'd0;
      y   <= 11'd0;
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      blk <= 1'b1;
    end else if (en) begin
      h_r <= h_next_s;
      v_r <= v_next_s;
      x   <= h_r;
      y   <= v_r;
      hs  <= hs_next_s;
      vs  <= vs_next_s;
      blk <= blk_next_s;
    end
  end

`ifdef VTG_FRAME_STROBE_EN
  // Frame strobe rides with the (0,0) output and holds across en=0 like the other outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else if (en) begin
      frame_start <= frame_next_s;
    end
  end
`else
  logic unused_frame_s;
  assign unused_frame_s = frame_next_s;
`endif

endmodule
